crossbar_scheduler: RTL and testbench
=====================================

CROSSBAR_SCHEDULER -- requirements
Module: crossbar_scheduler

Interface
REQ-001 Parameter DATA_W, default 8, payload width per port, SHALL be 1..32.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 in1_valid, in2_valid  input  1  beat present on input port.
REQ-005 in1_data, in2_data  input  DATA_W  beat payload.
REQ-006 in1_dest, in2_dest  input  1  destination: 0 = out1, 1 = out2; sampled only on first beat of a packet.
REQ-007 in1_last, in2_last  input  1  final beat of packet.
REQ-008 in1_ready, in2_ready  output  1  beat accepted when valid && ready.
REQ-009 out1_valid, out2_valid  output  1  registered beat present on output port.
REQ-010 out1_data, out2_data  output  DATA_W  registered payload.
REQ-011 out1_last, out2_last  output  1  registered last flag.
REQ-012 select  output  1  registered configuration: 0 = straight (in1->out1, in2->out2), 1 = cross (in1->out2, in2->out1).

Function
REQ-013 FSM states SHALL be IDLE, STRAIGHT and CROSS; select SHALL be 1 only for beats moved in CROSS.
REQ-014 In IDLE, in1_ready and in2_ready SHALL be 0, and requests SHALL be evaluated from in*_valid and in*_dest.
REQ-015 IDLE, no valid input: SHALL stay in IDLE.
REQ-016 IDLE, one valid input, or two with different dest: SHALL enter the configuration that serves all requests, and SHALL set an active flag per granted input.
REQ-017 IDLE, two valid inputs with equal dest: SHALL grant only the input holding round-robin priority, enter the configuration serving it, and toggle priority to the other input.
REQ-018 in*_ready SHALL be 1 exactly when the FSM is in STRAIGHT or CROSS and that input's active flag is set.
REQ-019 Each accepted beat SHALL appear on the routed output one cycle later with out*_valid = 1, data and last unchanged.
REQ-020 An output with no accepted beat that cycle SHALL drive out*_valid = 0; data and last SHALL hold their previous values.
REQ-021 An active flag SHALL clear on the cycle its last beat is accepted.
REQ-022 While locked, an inactive input whose valid first beat targets the output left free by the current configuration SHALL become active on the next cycle (join).
REQ-023 When all active flags clear in the same cycle, including simultaneous lasts, FSM SHALL return to IDLE; re-arbitration SHALL take exactly one IDLE cycle.
REQ-024 A dest change on an active input SHALL be ignored until its packet ends.
REQ-025 A valid deassertion mid-packet SHALL produce an output bubble only; the lock SHALL be held.
REQ-026 A single-beat packet (last on first beat) SHALL be accepted and SHALL release its active flag in one cycle.
REQ-027 Minimum latency from valid input in IDLE to output valid SHALL be 2 cycles (arbitrate, accept, register).

Reset
REQ-028 rst asserted SHALL immediately force IDLE, clear both active flags, set priority to in1, and drive all out*_valid, out*_data, out*_last, select and in*_ready to 0.
REQ-029 Reset mid-packet SHALL discard the packet; after rst deasserts, the first rising edge SHALL perform a fresh IDLE arbitration.

Structure
REQ-030 Shared package crossbar_pkg SHALL hold the state encodings (IDLE = 2'd0, STRAIGHT = 2'd1, CROSS = 2'd2) and the SEL_STRAIGHT / SEL_CROSS constants.
REQ-031 Two-input round-robin arbitration SHALL be a sub-module, crossbar_rr_arbiter (inputs: req[1:0], conflict, update; output: grant[1:0]); the datapath SHALL stay in the top.

Verification
REQ-032 in1 sends 3 beats 0x11, 0x12, 0x13 (last on 0x13) with dest = 1, in2 idle -> select = 1; out2 carries 0x11, 0x12, 0x13 on consecutive cycles with last on 0x13; out1_valid stays 0.
REQ-033 in1 dest = 0 with 0xA0, in2 dest = 1 with 0xB0, both single-beat -> both granted, select = 0, out1 = 0xA0 and out2 = 0xB0 in the same cycle.
REQ-034 Both inputs dest = 0, repeated twice after reset -> first packet from in1, then in2; second conflict: in1 first again (alternating grants).
REQ-035 in1 holds a 4-beat packet in CROSS; in2 starts a dest = 0 packet at beat 2 -> in2 joins; out1 carries in2 data without disturbing out2.
REQ-036 in2 valid drops for 2 cycles mid-packet -> out*_valid low for 2 cycles; the FSM stays in its state; the packet completes intact.
REQ-037 rst asserted during beat 2 of a 3-beat packet -> all outputs 0 within the same cycle; after release, a new packet is arbitrated from IDLE.

Source files
------------

// File: rtl/crossbar_pkg.sv
// rtl/crossbar_pkg.sv - shared state encodings, select constants and routing helpers
package crossbar_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STRAIGHT = 2'd1,
    CROSS    = 2'd2
  } state_t;

  localparam logic SEL_STRAIGHT = 1'b0;
  localparam logic SEL_CROSS    = 1'b1;

  // Round-robin priority holder: which input wins the next same-destination conflict.
  localparam logic PRIO_IN1 = 1'b0;
  localparam logic PRIO_IN2 = 1'b1;

  // Output index (0 = out1, 1 = out2) that input src (0 = in1, 1 = in2) reaches under sel.
  function automatic logic route(input logic sel, input logic src);
    return sel ^ src;
  endfunction

  // Configuration that carries input src to output dest.
  function automatic logic cfg_for(input logic dest, input logic src);
    return dest ^ src;
  endfunction

endpackage

// File: rtl/crossbar_rr_arbiter.sv
// rtl/crossbar_rr_arbiter.sv - two-input round-robin arbiter for the crossbar scheduler
module crossbar_rr_arbiter
  import crossbar_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       conflict,
  input  logic       update,
  output logic [1:0] grant
);

  logic prio;

  // Grant every requester unless both want the same output; then only the priority holder.
  always_comb begin
    grant = req;
    if (conflict) begin
      grant = (prio == PRIO_IN2) ? 2'b10 : 2'b01;
    end
  end

  // After a resolved conflict the loser holds priority for the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio <= PRIO_IN1;
    end else if (update && conflict) begin
      prio <= ~prio;
    end
  end

endmodule

// File: rtl/crossbar_scheduler.sv
// rtl/crossbar_scheduler.sv - 2x2 packet crossbar with lock/join scheduling and registered outputs
module crossbar_scheduler
  import crossbar_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in1_valid,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              in1_dest,
  input  logic              in1_last,
  output logic              in1_ready,
  input  logic              in2_valid,
  input  logic [DATA_W-1:0] in2_data,
  input  logic              in2_dest,
  input  logic              in2_last,
  output logic              in2_ready,
  output logic              out1_valid,
  output logic [DATA_W-1:0] out1_data,
  output logic              out1_last,
  output logic              out2_valid,
  output logic [DATA_W-1:0] out2_data,
  output logic              out2_last,
  output logic              select
);

  state_t state, state_nxt;
  logic   act1, act2, act1_nxt, act2_nxt;
  logic   locked, cur_sel;
  logic   acc1, acc2;
  logic   conflict, arb_update;
  logic [1:0] req, grant;

  logic              out1_fire, out2_fire;
  logic [DATA_W-1:0] out1_src_data, out2_src_data;
  logic              out1_src_last, out2_src_last;

  assign locked    = (state == STRAIGHT) || (state == CROSS);
  assign cur_sel   = (state == CROSS) ? SEL_CROSS : SEL_STRAIGHT;
  assign in1_ready = locked && act1;
  assign in2_ready = locked && act2;
  assign acc1      = in1_valid && in1_ready;
  assign acc2      = in2_valid && in2_ready;

  // Arbitration only matters in IDLE; a conflict is two requests for the same output.
  assign req        = {in2_valid, in1_valid};
  assign conflict   = in1_valid && in2_valid && (in1_dest == in2_dest);
  assign arb_update = (state == IDLE);

  crossbar_rr_arbiter u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .conflict (conflict),
    .update   (arb_update),
    .grant    (grant)
  );

  // State and per-input active flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      act1  <= 1'b0;
      act2  <= 1'b0;
    end else begin
      state <= state_nxt;
      act1  <= act1_nxt;
      act2  <= act2_nxt;
    end
  end

  // Arbitrate from IDLE, then hold the configuration until every active packet has ended.
  always_comb begin
    state_nxt = state;
    act1_nxt  = act1;
    act2_nxt  = act2;
    case (state)
      IDLE: begin
        act1_nxt = grant[0];
        act2_nxt = grant[1];
        if (grant[0]) begin
          state_nxt = (cfg_for(in1_dest, 1'b0) == SEL_CROSS) ? CROSS : STRAIGHT;
        end else if (grant[1]) begin
          state_nxt = (cfg_for(in2_dest, 1'b1) == SEL_CROSS) ? CROSS : STRAIGHT;
        end
      end
      STRAIGHT, CROSS: begin
        // A finished packet releases its input; an idle input may join the free output.
        if (acc1 && in1_last) begin
          act1_nxt = 1'b0;
        end else if (!act1 && in1_valid && (route(cur_sel, 1'b0) == in1_dest)) begin
          act1_nxt = 1'b1;
        end
        if (acc2 && in2_last) begin
          act2_nxt = 1'b0;
        end else if (!act2 && in2_valid && (route(cur_sel, 1'b1) == in2_dest)) begin
          act2_nxt = 1'b1;
        end
        if (!act1_nxt && !act2_nxt) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        act1_nxt  = 1'b0;
        act2_nxt  = 1'b0;
      end
    endcase
  end

  // Crossbar mux: pick the input feeding each output under the current configuration.
  always_comb begin
    out1_fire     = (cur_sel == SEL_CROSS) ? acc2 : acc1;
    out2_fire     = (cur_sel == SEL_CROSS) ? acc1 : acc2;
    out1_src_data = (cur_sel == SEL_CROSS) ? in2_data : in1_data;
    out2_src_data = (cur_sel == SEL_CROSS) ? in1_data : in2_data;
    out1_src_last = (cur_sel == SEL_CROSS) ? in2_last : in1_last;
    out2_src_last = (cur_sel == SEL_CROSS) ? in1_last : in2_last;
  end

  // Output registers: valid pulses per accepted beat, payload holds across bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out1_valid <= 1'b0;
      out1_data  <= '0;
      out1_last  <= 1'b0;
      out2_valid <= 1'b0;
      out2_data  <= '0;
      out2_last  <= 1'b0;
      select     <= SEL_STRAIGHT;
    end else begin
      select     <= cur_sel;
      out1_valid <= out1_fire;
      out2_valid <= out2_fire;
      if (out1_fire) begin
        out1_data <= out1_src_data;
        out1_last <= out1_src_last;
      end
      if (out2_fire) begin
        out2_data <= out2_src_data;
        out2_last <= out2_src_last;
      end
    end
  end

endmodule

// File: tb/tb_crossbar_scheduler.sv
// tb/tb_crossbar_scheduler.sv - self-checking bench for crossbar_scheduler
module tb_crossbar_scheduler;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in1_valid, in2_valid, in1_dest, in2_dest, in1_last, in2_last;
  logic [DW-1:0] in1_data, in2_data;
  logic          in1_ready, in2_ready;
  logic          out1_valid, out2_valid, out1_last, out2_last, select;
  logic [DW-1:0] out1_data, out2_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  crossbar_scheduler #(.DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_dest(in1_dest), .in1_last(in1_last), .in1_ready(in1_ready),
    .in2_valid(in2_valid), .in2_data(in2_data), .in2_dest(in2_dest), .in2_last(in2_last), .in2_ready(in2_ready),
    .out1_valid(out1_valid), .out1_data(out1_data), .out1_last(out1_last),
    .out2_valid(out2_valid), .out2_data(out2_data), .out2_last(out2_last),
    .select(select)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h (cycle %0d)", nm, a, e, cyc);
    end
  endtask

  // ---------------- stimulus queues and drivers ----------------
  typedef struct { bit v; logic [7:0] d; bit dest; bit last; } beat_t;
  beat_t q1[$];
  beat_t q2[$];

  task automatic push1(input logic [7:0] d, input bit de, input bit la);
    beat_t b; b.v = 1; b.d = d; b.dest = de; b.last = la; q1.push_back(b);
  endtask
  task automatic push2(input logic [7:0] d, input bit de, input bit la);
    beat_t b; b.v = 1; b.d = d; b.dest = de; b.last = la; q2.push_back(b);
  endtask
  task automatic bub2();
    beat_t b; b.v = 0; b.d = 8'h00; b.dest = 0; b.last = 0; q2.push_back(b);
  endtask

  initial begin : drv1
    bit a, pres;
    pres = 0;
    in1_valid = 0; in1_data = '0; in1_dest = 0; in1_last = 0;
    forever begin
      @(negedge clk); a = in1_valid && in1_ready;
      @(posedge clk); #1;
      if (pres && q1.size() > 0 && (a || !q1[0].v)) void'(q1.pop_front());
      if (q1.size() > 0) begin
        in1_valid = q1[0].v; in1_data = q1[0].d; in1_dest = q1[0].dest; in1_last = q1[0].last; pres = 1;
      end else begin
        in1_valid = 0; pres = 0;
      end
    end
  end

  initial begin : drv2
    bit a, pres;
    pres = 0;
    in2_valid = 0; in2_data = '0; in2_dest = 0; in2_last = 0;
    forever begin
      @(negedge clk); a = in2_valid && in2_ready;
      @(posedge clk); #1;
      if (pres && q2.size() > 0 && (a || !q2[0].v)) void'(q2.pop_front());
      if (q2.size() > 0) begin
        in2_valid = q2[0].v; in2_data = q2[0].d; in2_dest = q2[0].dest; in2_last = q2[0].last; pres = 1;
      end else begin
        in2_valid = 0; pres = 0;
      end
    end
  end

  // ---------------- behavioural model ----------------
  // m_cfg: -1 = no lock, otherwise the configuration; an input i reaches output i ^ m_cfg.
  int         m_cfg;
  bit         m_act [2];
  bit         m_prio;
  bit         m_sel;
  bit         m_ov [2];
  bit         m_ol [2];
  logic [7:0] m_od [2];
  bit         mv [2], md [2], ml [2], nact [2];
  logic [7:0] mdat [2];
  int         w, o;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cfg = -1; m_prio = 0; m_sel = 0;
      for (int i = 0; i < 2; i++) begin
        m_act[i] = 0; m_ov[i] = 0; m_ol[i] = 0; m_od[i] = 8'h00;
      end
    end else begin
      mv[0] = in1_valid; md[0] = in1_dest; ml[0] = in1_last; mdat[0] = in1_data;
      mv[1] = in2_valid; md[1] = in2_dest; ml[1] = in2_last; mdat[1] = in2_data;
      m_sel = (m_cfg == 1);
      m_ov[0] = 0; m_ov[1] = 0;
      nact[0] = m_act[0]; nact[1] = m_act[1];
      if (m_cfg < 0) begin
        if (mv[0] && mv[1] && md[0] == md[1]) begin
          w = m_prio ? 1 : 0;
          nact[w] = 1;
          m_cfg = int'(md[w]) ^ w;
          m_prio = !m_prio;
        end else begin
          nact[0] = mv[0]; nact[1] = mv[1];
          if (mv[0]) m_cfg = int'(md[0]);
          else if (mv[1]) m_cfg = int'(md[1]) ^ 1;
        end
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (mv[i] && m_act[i]) begin
            o = i ^ m_cfg;
            m_ov[o] = 1; m_od[o] = mdat[i]; m_ol[o] = ml[i];
            if (ml[i]) nact[i] = 0;
          end else if (!m_act[i] && mv[i] && ((int'(md[i]) ^ i) == m_cfg)) begin
            nact[i] = 1;
          end
        end
        if (!nact[0] && !nact[1]) m_cfg = -1;
      end
      m_act[0] = nact[0]; m_act[1] = nact[1];
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("ready1", 32'(in1_ready), 32'(m_cfg >= 0 && m_act[0]));
    chk("ready2", 32'(in2_ready), 32'(m_cfg >= 0 && m_act[1]));
    chk("select", 32'(select), 32'(m_sel));
    chk("out1_valid", 32'(out1_valid), 32'(m_ov[0]));
    chk("out2_valid", 32'(out2_valid), 32'(m_ov[1]));
    chk("out1_data", 32'(out1_data), 32'(m_od[0]));
    chk("out2_data", 32'(out2_data), 32'(m_od[1]));
    chk("out1_last", 32'(out1_last), 32'(m_ol[0]));
    chk("out2_last", 32'(out2_last), 32'(m_ol[1]));
  end

  // ---------------- output log for literal expectations ----------------
  typedef struct { logic [7:0] d; logic l; logic s; int t; } ent_t;
  ent_t log1[$];
  ent_t log2[$];
  int   in_start = -1;

  always @(negedge clk) begin
    if (out1_valid) log1.push_back('{d: out1_data, l: out1_last, s: select, t: cyc});
    if (out2_valid) log2.push_back('{d: out2_data, l: out2_last, s: select, t: cyc});
    if (in_start < 0 && (in1_valid || in2_valid)) in_start = cyc;
  end

  task automatic clear_logs();
    log1.delete(); log2.delete(); in_start = -1;
  endtask

  task automatic chk_beat(input string nm, input int op, input int i,
                          input logic [7:0] d, input logic la, input logic se);
    ent_t e;
    checks++;
    if (i >= ((op == 1) ? log1.size() : log2.size())) begin
      errors++;
      $display("FAIL %s beat %0d missing on out%0d", nm, i, op);
    end else begin
      e = (op == 1) ? log1[i] : log2[i];
      chk({nm, "_data"}, 32'(e.d), 32'(d));
      chk({nm, "_last"}, 32'(e.l), 32'(la));
      chk({nm, "_sel"}, 32'(e.s), 32'(se));
    end
  endtask

  task automatic settle(input string nm);
    int n;
    n = 0;
    while ((q1.size() > 0 || q2.size() > 0 || m_cfg >= 0 || in1_valid || in2_valid) && n < 300) begin
      @(posedge clk); n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL %s timeout got %0d cycles want under 300", nm, n);
    end
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1;
    repeat (2) @(posedge clk);
    #2;
    rst = 0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int n;
    rst = 1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_out1_valid", 32'(out1_valid), 0);
    chk("rst_out2_valid", 32'(out2_valid), 0);
    chk("rst_select", 32'(select), 0);
    chk("rst_ready", 32'({in1_ready, in2_ready}), 0);
    chk("rst_data", 32'({out1_data, out2_data, out1_last, out2_last}), 0);
    rst = 0;

    // in1 -> out2, three beats
    clear_logs();
    push1(8'h11, 1, 0); push1(8'h12, 1, 0); push1(8'h13, 1, 1);
    settle("s1");
    chk("s1_n_out2", log2.size(), 3);
    chk("s1_n_out1", log1.size(), 0);
    chk_beat("s1_b0", 2, 0, 8'h11, 0, 1);
    chk_beat("s1_b1", 2, 1, 8'h12, 0, 1);
    chk_beat("s1_b2", 2, 2, 8'h13, 1, 1);
    if (log2.size() == 3) begin
      chk("s1_consecutive", log2[2].t - log2[0].t, 2);
      chk("s1_latency", log2[0].t - in_start, 2);
    end

    // different destinations, both single-beat, straight
    clear_logs();
    push1(8'hA0, 0, 1); push2(8'hB0, 1, 1);
    settle("s2");
    chk("s2_n_out1", log1.size(), 1);
    chk("s2_n_out2", log2.size(), 1);
    chk_beat("s2_out1", 1, 0, 8'hA0, 1, 0);
    chk_beat("s2_out2", 2, 0, 8'hB0, 1, 0);
    if (log1.size() == 1 && log2.size() == 1) chk("s2_same_cycle", log1[0].t, log2[0].t);

    // conflict on out1 after reset: in1 first, then in2
    do_reset();
    clear_logs();
    push1(8'h31, 0, 0); push1(8'h32, 0, 1);
    push2(8'h41, 0, 0); push2(8'h42, 0, 1);
    settle("s3a");
    chk("s3a_n_out1", log1.size(), 4);
    chk_beat("s3a_b0", 1, 0, 8'h31, 0, 0);
    chk_beat("s3a_b1", 1, 1, 8'h32, 1, 0);
    chk_beat("s3a_b2", 1, 2, 8'h41, 0, 1);
    chk_beat("s3a_b3", 1, 3, 8'h42, 1, 1);

    // repeat after reset: priority is back at in1
    do_reset();
    clear_logs();
    push1(8'h51, 0, 0); push1(8'h52, 0, 1);
    push2(8'h61, 0, 0); push2(8'h62, 0, 1);
    settle("s3b");
    chk("s3b_n_out1", log1.size(), 4);
    chk_beat("s3b_b0", 1, 0, 8'h51, 0, 0);
    chk_beat("s3b_b2", 1, 2, 8'h61, 0, 1);

    // third conflict without reset: priority has moved to in2
    clear_logs();
    push1(8'h71, 0, 1); push2(8'h81, 0, 1);
    settle("s3c");
    chk("s3c_n_out1", log1.size(), 2);
    chk_beat("s3c_b0", 1, 0, 8'h81, 1, 1);
    chk_beat("s3c_b1", 1, 1, 8'h71, 1, 0);

    // in1 locked in cross; in2 joins on out1 at beat 2; in1 dest flip mid-packet ignored
    clear_logs();
    push1(8'hC1, 1, 0); push1(8'hC2, 1, 0); push1(8'hC3, 0, 0); push1(8'hC4, 1, 1);
    bub2(); push2(8'hD1, 0, 0); push2(8'hD2, 0, 1);
    settle("s4");
    chk("s4_n_out2", log2.size(), 4);
    chk("s4_n_out1", log1.size(), 2);
    chk_beat("s4_c1", 2, 0, 8'hC1, 0, 1);
    chk_beat("s4_c3", 2, 2, 8'hC3, 0, 1);
    chk_beat("s4_c4", 2, 3, 8'hC4, 1, 1);
    chk_beat("s4_d1", 1, 0, 8'hD1, 0, 1);
    chk_beat("s4_d2", 1, 1, 8'hD2, 1, 1);
    if (log1.size() == 2 && log2.size() == 4) chk("s4_join_cycle", log1[0].t, log2[1].t);

    // in2 valid drops for two cycles mid-packet
    clear_logs();
    push2(8'hE1, 1, 0); push2(8'hE2, 1, 0); bub2(); bub2(); push2(8'hE3, 1, 1);
    settle("s5");
    chk("s5_n_out2", log2.size(), 3);
    chk("s5_n_out1", log1.size(), 0);
    chk_beat("s5_e2", 2, 1, 8'hE2, 0, 0);
    chk_beat("s5_e3", 2, 2, 8'hE3, 1, 0);
    if (log2.size() == 3) chk("s5_bubble_gap", log2[2].t - log2[1].t, 3);

    // reset during beat 2 of a 3-beat packet
    clear_logs();
    push1(8'h91, 0, 0); push1(8'h92, 0, 0); push1(8'h93, 0, 1);
    n = 0;
    while (log1.size() == 0 && n < 50) begin @(negedge clk); #1; n++; end
    chk("s6_first_beat", 32'(log1.size() > 0), 1);
    rst = 1;
    #1;
    chk("s6_rst_valid", 32'({out1_valid, out2_valid}), 0);
    chk("s6_rst_ready", 32'({in1_ready, in2_ready}), 0);
    chk("s6_rst_payload", 32'({out1_data, out2_data, out1_last, out2_last, select}), 0);
    q1.delete();
    repeat (2) @(posedge clk);
    #2;
    rst = 0;
    repeat (2) @(posedge clk);
    #2;
    clear_logs();
    push2(8'h9A, 0, 1);
    settle("s6");
    chk("s6_n_out1", log1.size(), 1);
    chk("s6_n_out2", log2.size(), 0);
    chk_beat("s6_new", 1, 0, 8'h9A, 1, 1);
    if (log1.size() == 1) chk("s6_latency", log1[0].t - in_start, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
